// File: rtl/clock_monitor_selector.sv
// Clock monitor and selector: measures N reference clocks per gate window,
// qualifies them, and selects one by priority with override and hold-off.
module clock_monitor_selector #(
    parameter int NumberOfClocks_Gen = 4,
    parameter int DivLog2_Gen        = 7,
    parameter int GateCycles_Gen     = 50000,
    parameter int CntWidth_Gen       = 16,
    parameter int MinCount_Gen       = 70,
    parameter int MaxCount_Gen       = 86,
    parameter int GoodWindows_Gen    = 2,
    parameter int HoldoffWindows_Gen = 2,
    parameter int RstStretch_Gen     = 8
) (
    input  logic                                       MhzXClk_ClkIn,
    input  logic                                       SysRstN_RstIn,
    input  logic [NumberOfClocks_Gen-1:0]              MonClk_ClkIn,
    input  logic                                       ManualEnable_EnIn,
    input  logic [NumberOfClocks_Gen-1:0]              ManualSelect_DatIn,
    input  logic                                       RevertEnable_EnIn,
    output logic [NumberOfClocks_Gen-1:0]              ClkSelected_DatOut,
    output logic [NumberOfClocks_Gen-1:0]              ClkAvailable_DatOut,
    output logic [NumberOfClocks_Gen*CntWidth_Gen-1:0] ClkFreq_DatOut,
    output logic                                       FreqValid_ValOut,
    output logic [15:0]                                SwitchCount_DatOut,
    output logic                                       NoClock_ErrOut,
    output logic                                       ClockRstN_RstOut
);

    localparam int N     = NumberOfClocks_Gen;
    localparam int CW    = CntWidth_Gen;
    localparam int WinW  = (GateCycles_Gen > 1) ? $clog2(GateCycles_Gen) : 1;
    localparam int GoodW = $clog2(GoodWindows_Gen + 1);
    localparam int HoldW = $clog2(HoldoffWindows_Gen + 1);
    localparam int StrW  = $clog2(RstStretch_Gen + 1);

    localparam logic [WinW-1:0]        WinLast  = WinW'(GateCycles_Gen - 1);
    localparam logic [WinW-1:0]        WinOne   = WinW'(1);
    localparam logic [CW-1:0]          CntOne   = CW'(1);
    localparam logic [CW-1:0]          MinC     = CW'(MinCount_Gen);
    localparam logic [CW-1:0]          MaxC     = CW'(MaxCount_Gen);
    localparam logic [GoodW-1:0]       GoodMax  = GoodW'(GoodWindows_Gen);
    localparam logic [GoodW-1:0]       GoodOne  = GoodW'(1);
    localparam logic [HoldW-1:0]       HoldMax  = HoldW'(HoldoffWindows_Gen);
    localparam logic [HoldW-1:0]       HoldOne  = HoldW'(1);
    localparam logic [StrW-1:0]        StrLoad  = StrW'(RstStretch_Gen);
    localparam logic [StrW-1:0]        StrOne   = StrW'(1);
    localparam logic [N-1:0]           NOne     = N'(1);
    localparam logic [DivLog2_Gen-1:0] DivOne   = DivLog2_Gen'(1);

    typedef enum logic [1:0] {
        NoClk_St,
        Locked_St,
        Holdoff_St
    } state_t;

    logic [N-1:0] msb;

    // Prescalers live in the monitored domains and free-run without reset
    for (genvar i = 0; i < N; i++) begin : g_div
        logic [DivLog2_Gen-1:0] div_q, div_d;

        always_comb div_d = div_q + DivOne;

        always_ff @(posedge MonClk_ClkIn[i]) div_q <= div_d;

        assign msb[i] = div_q[DivLog2_Gen-1];
    end

    logic [N-1:0]      sync1_q, sync1_d;
    logic [N-1:0]      sync2_q, sync2_d;
    logic [N-1:0]      sync3_q, sync3_d;
    logic [N-1:0]      rise;
    logic [WinW-1:0]   win_cnt_q, win_cnt_d;
    logic              tc;
    logic              fv_q, fv_d;
    logic [CW-1:0]     edge_cnt_q [N];
    logic [CW-1:0]     edge_cnt_d [N];
    logic [CW-1:0]     freq_q [N];
    logic [CW-1:0]     freq_d [N];
    logic [CW-1:0]     meas [N];
    logic [GoodW-1:0]  good_q [N];
    logic [GoodW-1:0]  good_d [N];
    logic [N-1:0]      avail_q, avail_d;
    logic [N-1:0]      in_range;

    assign rise = sync2_q & ~sync3_q;
    assign tc   = (win_cnt_q == WinLast);

    always_comb begin
        sync1_d   = msb;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        win_cnt_d = tc ? '0 : win_cnt_q + WinOne;
        fv_d      = tc;
        avail_d   = avail_q;
        in_range  = '0;
        for (int i = 0; i < N; i++) begin
            meas[i] = edge_cnt_q[i];
            if (rise[i] && (edge_cnt_q[i] != '1)) begin
                meas[i] = edge_cnt_q[i] + CntOne;
            end
            in_range[i]   = (meas[i] >= MinC) && (meas[i] <= MaxC);
            edge_cnt_d[i] = tc ? '0 : meas[i];
            freq_d[i]     = tc ? meas[i] : freq_q[i];
            good_d[i]     = good_q[i];
            if (tc) begin
                if (in_range[i]) begin
                    if (good_q[i] != GoodMax) begin
                        good_d[i] = good_q[i] + GoodOne;
                    end
                    avail_d[i] = (good_d[i] == GoodMax);
                end else begin
                    good_d[i]  = '0;
                    avail_d[i] = 1'b0;
                end
            end
        end
    end

    // Selection runs on the cycle after TC, when availability is fresh
    state_t           state_q, state_d;
    logic [N-1:0]     sel_q, sel_d;
    logic [N-1:0]     tgt_q, tgt_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [15:0]      swc_q, swc_d;
    logic [StrW-1:0]  rst_cnt_q, rst_cnt_d;
    logic             clk_rstn_q, clk_rstn_d;
    logic             man_ok, lost, better, switch_now;
    logic [N-1:0]     low_avail, cand;

    always_comb begin
        man_ok    = ManualEnable_EnIn && $onehot(ManualSelect_DatIn) &&
                    (|(ManualSelect_DatIn & avail_q));
        low_avail = avail_q & (~avail_q + NOne);
        cand      = man_ok ? ManualSelect_DatIn : low_avail;
        lost      = (|sel_q) && !(|(sel_q & avail_q));
        better    = RevertEnable_EnIn && (|cand) && (cand < sel_q);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        hold_d  = hold_q;
        if (fv_q) begin
            unique case (state_q)
                NoClk_St: begin
                    if (|cand) begin
                        sel_d   = cand;
                        state_d = Locked_St;
                    end
                end
                Locked_St, Holdoff_St: begin
                    if (lost) begin
                        sel_d   = cand;
                        state_d = (|cand) ? Locked_St : NoClk_St;
                        hold_d  = '0;
                    end else if (man_ok && (cand != sel_q)) begin
                        sel_d   = cand;
                        state_d = Locked_St;
                        hold_d  = '0;
                    end else if (state_q == Holdoff_St) begin
                        if (better && (cand == tgt_q)) begin
                            if (hold_q >= HoldMax) begin
                                sel_d   = cand;
                                state_d = Locked_St;
                                hold_d  = '0;
                            end else begin
                                hold_d = hold_q + HoldOne;
                            end
                        end else begin
                            state_d = Locked_St;
                            hold_d  = '0;
                        end
                    end else if (better) begin
                        state_d = Holdoff_St;
                        tgt_d   = cand;
                        hold_d  = HoldOne;
                    end
                end
                default: state_d = NoClk_St;
            endcase
        end
    end

    always_comb begin
        switch_now = (sel_d != sel_q);
        swc_d      = swc_q;
        if (switch_now && (swc_q != 16'hFFFF)) begin
            swc_d = swc_q + 16'd1;
        end
        rst_cnt_d = rst_cnt_q;
        if (switch_now) begin
            rst_cnt_d = StrLoad;
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - StrOne;
        end
        clk_rstn_d = (rst_cnt_d == '0) && (|sel_d);
    end

    always_ff @(posedge MhzXClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            win_cnt_q  <= '0;
            fv_q       <= 1'b0;
            avail_q    <= '0;
            for (int i = 0; i < N; i++) begin
                edge_cnt_q[i] <= '0;
                freq_q[i]     <= '0;
                good_q[i]     <= '0;
            end
            state_q    <= NoClk_St;
            sel_q      <= '0;
            tgt_q      <= '0;
            hold_q     <= '0;
            swc_q      <= '0;
            rst_cnt_q  <= '0;
            clk_rstn_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            win_cnt_q  <= win_cnt_d;
            fv_q       <= fv_d;
            avail_q    <= avail_d;
            for (int i = 0; i < N; i++) begin
                edge_cnt_q[i] <= edge_cnt_d[i];
                freq_q[i]     <= freq_d[i];
                good_q[i]     <= good_d[i];
            end
            state_q    <= state_d;
            sel_q      <= sel_d;
            tgt_q      <= tgt_d;
            hold_q     <= hold_d;
            swc_q      <= swc_d;
            rst_cnt_q  <= rst_cnt_d;
            clk_rstn_q <= clk_rstn_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_freq
        assign ClkFreq_DatOut[i*CW +: CW] = freq_q[i];
    end

    assign ClkSelected_DatOut  = sel_q;
    assign ClkAvailable_DatOut = avail_q;
    assign FreqValid_ValOut    = fv_q;
    assign SwitchCount_DatOut  = swc_q;
    assign NoClock_ErrOut      = ~|sel_q;
    assign ClockRstN_RstOut    = clk_rstn_q;

endmodule

// File: tb/tb_clock_monitor_selector.sv
// Bench for clock_monitor_selector: directed window table, randomized
// windows against a behavioural model, reset and timing corner cases.
`timescale 1ns/1ps
module tb_clock_monitor_selector;

    localparam int N     = 4;
    localparam int CW    = 16;
    localparam int G     = 320;
    localparam int DL    = 2;
    localparam int MINC  = 18;
    localparam int MAXC  = 22;
    localparam int GOODW = 2;
    localparam int HOLDW = 2;
    localparam int STR   = 8;
    localparam int SYSNS = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    wire  [N-1:0]    mclk;
    logic            man_en = 1'b0;
    logic [N-1:0]    man_sel = '0;
    logic            rev = 1'b0;
    logic [N-1:0]    sel, avail;
    logic [N*CW-1:0] freq;
    logic            fv;
    logic [15:0]     swc;
    logic            noclk, crstn;

    int per [N];
    int prev_per [N];
    int checks = 0;
    int failures = 0;

    clock_monitor_selector #(
        .NumberOfClocks_Gen(N), .DivLog2_Gen(DL), .GateCycles_Gen(G),
        .CntWidth_Gen(CW), .MinCount_Gen(MINC), .MaxCount_Gen(MAXC),
        .GoodWindows_Gen(GOODW), .HoldoffWindows_Gen(HOLDW),
        .RstStretch_Gen(STR)
    ) dut (
        .MhzXClk_ClkIn(clk), .SysRstN_RstIn(rst_n), .MonClk_ClkIn(mclk),
        .ManualEnable_EnIn(man_en), .ManualSelect_DatIn(man_sel),
        .RevertEnable_EnIn(rev), .ClkSelected_DatOut(sel),
        .ClkAvailable_DatOut(avail), .ClkFreq_DatOut(freq),
        .FreqValid_ValOut(fv), .SwitchCount_DatOut(swc),
        .NoClock_ErrOut(noclk), .ClockRstN_RstOut(crstn)
    );

    always #(SYSNS/2) clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_mclk
        logic c = 1'b0;
        assign mclk[g] = c;
        initial begin
            #3;
            forever begin
                if (per[g] == 0) begin
                    c = 1'b0;
                    #5;
                end else begin
                    #(per[g] / 2) c = ~c;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int code2per(input logic [1:0] c);
        case (c)
            2'd1:    return 40;
            2'd2:    return 30;
            2'd3:    return 60;
            default: return 0;
        endcase
    endfunction

    // Nominal edges per window: window time over prescaled period
    function automatic int nominal(input int p);
        if (p == 0) return 0;
        return (G * SYSNS) / (p * (1 << DL));
    endfunction

    int       m_good [N];
    bit [3:0] m_avail;
    int       m_sel;
    bit       m_holding;
    int       m_tgt;
    int       m_wait;
    int       m_swc;
    logic [3:0] last_sel;

    task automatic model_window();
        int n, mi, cand, new_sel;
        bit man_ok;
        for (int i = 0; i < N; i++) begin
            n = nominal(per[i]);
            if (n >= MINC && n <= MAXC) begin
                if (m_good[i] < GOODW) m_good[i]++;
            end else begin
                m_good[i] = 0;
            end
            m_avail[i] = (m_good[i] == GOODW);
        end
        mi = -1;
        if ($countones(man_sel) == 1)
            for (int i = 0; i < N; i++) if (man_sel[i]) mi = i;
        man_ok = man_en && (mi >= 0) && m_avail[mi];
        cand = -1;
        if (man_ok) cand = mi;
        else for (int i = N - 1; i >= 0; i--) if (m_avail[i]) cand = i;
        new_sel = m_sel;
        if (m_sel < 0) begin
            new_sel = cand;
        end else if (!m_avail[m_sel]) begin
            new_sel = cand;
            m_holding = 0;
        end else if (man_ok && cand != m_sel) begin
            new_sel = cand;
            m_holding = 0;
        end else if (m_holding) begin
            if (rev && cand == m_tgt) begin
                m_wait++;
                if (m_wait > HOLDW) begin
                    new_sel = cand;
                    m_holding = 0;
                end
            end else begin
                m_holding = 0;
            end
        end else if (rev && cand >= 0 && cand < m_sel) begin
            m_holding = 1;
            m_tgt = cand;
            m_wait = 1;
        end
        if (new_sel != m_sel) m_swc++;
        m_sel = new_sel;
    endtask

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic run_window(input logic [3:0] e_avail,
                              input logic [3:0] e_sel, input int e_swc);
        bit seen;
        bit sw;
        int f, p, d;
        seen = 0;
        for (int c = 0; c < G + 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (fv) seen = 1;
        end
        chk("freqvalid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < N; i++) begin
            f = int'(freq[i*CW +: CW]);
            p = per[i];
            if (p == prev_per[i]) begin
                if (p == 0) begin
                    chk($sformatf("freq_stopped%0d", i), 32'(f), 32'd0);
                end else begin
                    d = f * p * (1 << DL) - G * SYSNS;
                    if (d < 0) d = -d;
                    chk($sformatf("freq_tol%0d_cnt%0d", i, f),
                        32'(d <= p * (1 << DL)), 32'd1);
                end
            end
        end
        chk("available", 32'(avail), 32'(e_avail));
        @(posedge clk);
        #1;
        sw = (e_sel != last_sel);
        chk("freqvalid_pulse", 32'(fv), 32'd0);
        chk("selected", 32'(sel), 32'(e_sel));
        chk("switch_count", 32'(swc), 32'(e_swc));
        chk("noclock", 32'(noclk), 32'(e_sel == 0));
        chk("clkrstn_eval1", 32'(crstn), 32'(!sw && e_sel != 0));
        if (sw && e_sel != 0) begin
            repeat (STR - 1) @(posedge clk);
            #1;
            chk("clkrstn_last_low", 32'(crstn), 32'd0);
            @(posedge clk);
            #1;
            chk("clkrstn_release", 32'(crstn), 32'd1);
        end
        for (int i = 0; i < N; i++) prev_per[i] = per[i];
        last_sel = e_sel;
    endtask

    typedef struct {
        logic [7:0] cfg;
        logic       men;
        logic [3:0] msel;
        logic       rv;
        logic [3:0] e_avail;
        logic [3:0] e_sel;
        int         e_swc;
    } row_t;

    row_t tbl [20];

    task automatic check_reset_values();
        chk("rst_selected", 32'(sel), 32'd0);
        chk("rst_available", 32'(avail), 32'd0);
        chk("rst_freq", 32'(freq == '0), 32'd1);
        chk("rst_freqvalid", 32'(fv), 32'd0);
        chk("rst_switch_count", 32'(swc), 32'd0);
        chk("rst_noclock", 32'(noclk), 32'd1);
        chk("rst_clkrstn", 32'(crstn), 32'd0);
    endtask

    initial begin
        int r, k, first;
        tbl[0]  = '{8'h55, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 0};
        tbl[1]  = '{8'h55, 1'b0, 4'h0, 1'b0, 4'hF, 4'h1, 1};
        tbl[2]  = '{8'h54, 1'b0, 4'h0, 1'b0, 4'hE, 4'h2, 2};
        tbl[3]  = '{8'h56, 1'b0, 4'h0, 1'b0, 4'hE, 4'h2, 2};
        tbl[4]  = '{8'h55, 1'b0, 4'h0, 1'b1, 4'hE, 4'h2, 2};
        tbl[5]  = '{8'h55, 1'b0, 4'h0, 1'b1, 4'hF, 4'h2, 2};
        tbl[6]  = '{8'h55, 1'b0, 4'h0, 1'b1, 4'hF, 4'h2, 2};
        tbl[7]  = '{8'h55, 1'b0, 4'h0, 1'b1, 4'hF, 4'h1, 3};
        tbl[8]  = '{8'h54, 1'b0, 4'h0, 1'b0, 4'hE, 4'h2, 4};
        tbl[9]  = '{8'h55, 1'b0, 4'h0, 1'b0, 4'hE, 4'h2, 4};
        tbl[10] = '{8'h55, 1'b0, 4'h0, 1'b0, 4'hF, 4'h2, 4};
        tbl[11] = '{8'h55, 1'b0, 4'h0, 1'b0, 4'hF, 4'h2, 4};
        tbl[12] = '{8'h55, 1'b1, 4'h8, 1'b0, 4'hF, 4'h8, 5};
        tbl[13] = '{8'h55, 1'b1, 4'hC, 1'b1, 4'hF, 4'h8, 5};
        tbl[14] = '{8'h55, 1'b1, 4'hC, 1'b1, 4'hF, 4'h8, 5};
        tbl[15] = '{8'h55, 1'b1, 4'hC, 1'b1, 4'hF, 4'h1, 6};
        tbl[16] = '{8'h55, 1'b1, 4'h8, 1'b1, 4'hF, 4'h8, 7};
        tbl[17] = '{8'h15, 1'b1, 4'h8, 1'b1, 4'h7, 4'h1, 8};
        tbl[18] = '{8'h00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 9};
        tbl[19] = '{8'h00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 9};

        for (int i = 0; i < N; i++) begin
            per[i] = 40;
            prev_per[i] = 40;
            m_good[i] = 0;
        end
        m_avail = '0;
        m_sel = -1;
        m_holding = 0;
        m_tgt = -1;
        m_wait = 0;
        m_swc = 0;
        last_sel = '0;

        repeat (5) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) per[i] = code2per(tbl[t].cfg[2*i +: 2]);
            man_en  = tbl[t].men;
            man_sel = tbl[t].msel;
            rev     = tbl[t].rv;
            model_window();
            run_window(tbl[t].e_avail, tbl[t].e_sel, tbl[t].e_swc);
        end

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                per[i] = (r <= 6) ? 40 : (r == 7) ? 0 : (r == 8) ? 30 : 60;
            end
            man_en = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, 3);
            man_sel = (k <= 1) ? onehot($urandom_range(0, N - 1)) :
                      (k == 2) ? 4'h0 : 4'($urandom_range(0, 15));
            rev = 1'($urandom_range(0, 1));
            model_window();
            run_window(m_avail, onehot(m_sel), m_swc);
        end

        repeat ($urandom_range(20, 200)) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_values();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        first = -1;
        for (int n = 1; n <= G + 20; n++) begin
            @(posedge clk);
            #1;
            if (fv) begin
                first = n;
                break;
            end
        end
        chk("first_freqvalid_edge", 32'(first), 32'(G));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
